// File: rtl/fir_pkg.sv
// fir_pkg
// Shared defaults and the feeder FSM state type for the FIR sample path.
// The feeder and the downstream MAC stage both import this package so that
// widths and tap count agree across the datapath.
package fir_pkg;

  localparam int NTAPS_DEF    = 128;
  localparam int SAMPLE_W_DEF = 16;
  localparam int COEF_W_DEF   = 16;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    STREAM  = 2'd2,
    ADVANCE = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_sample_ram.sv
// fir_sample_ram
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// The array itself has no reset so it maps onto block RAM. The read register
// has an async reset and loads zero whenever no read is requested, which keeps
// downstream data at zero between read bursts.
// Ports:
//   clk, reset      clock, async active-high reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr        read request and address
//   rdata           registered read data, one cycle after re
module fir_sample_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rdata_r;

  // Memory array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; zero when no read is requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= '0;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
// Accepts one audio sample at a time into a circular history buffer and then
// streams NTAPS (coefficient, delayed sample) pairs to a MAC stage, newest
// sample first. History is zeroed after every reset; coefficients are not.
// Ports:
//   clk, reset                  clock, async active-high reset
//   sample_in/valid/ready       sample input handshake
//   overrun                     pulse: sample offered while not ready (dropped)
//   coef_we/addr/wdata          coefficient write port (honoured only in IDLE)
//   mac_a, mac_b                coefficient and delayed sample to the MAC
//   mac_valid/first/last        pair qualifier and sum framing
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int NTAPS    = NTAPS_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int COEF_W   = COEF_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SAMPLE_W-1:0]      sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic                     overrun,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic [COEF_W-1:0]        mac_a,
  output logic [SAMPLE_W-1:0]      mac_b,
  output logic                     mac_valid,
  output logic                     mac_first,
  output logic                     mac_last
);

  localparam int AW = $clog2(NTAPS);
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);
  localparam logic [AW-1:0] K_ONE  = AW'(1);

  fir_state_e          state_r, state_next_s;
  logic [AW-1:0]       k_r, k_next_s;
  logic [AW-1:0]       wptr_r, wptr_next_s;
  logic                ready_r, ready_next_s;
  logic                valid_r, first_r, last_r;
  logic                hist_we_s, coef_we_s, rd_en_s;
  logic [AW-1:0]       hist_waddr_s, hist_raddr_s;
  logic [SAMPLE_W-1:0] hist_wdata_s;

  // Next-state, counter and memory-control decode.
  always_comb begin
    state_next_s = state_r;
    k_next_s     = k_r;
    wptr_next_s  = wptr_r;
    hist_we_s    = 1'b0;
    hist_waddr_s = wptr_r;
    hist_wdata_s = '0;
    coef_we_s    = 1'b0;
    rd_en_s      = 1'b0;
    case (state_r)
      CLEAR: begin
        // k doubles as the clear address.
        hist_we_s    = 1'b1;
        hist_waddr_s = k_r;
        if (k_r == K_LAST) begin
          state_next_s = IDLE;
          k_next_s     = '0;
        end else begin
          k_next_s = k_r + K_ONE;
        end
      end
      IDLE: begin
        coef_we_s = coef_we;
        if (sample_valid) begin
          hist_we_s    = 1'b1;
          hist_wdata_s = sample_in;
          state_next_s = STREAM;
          k_next_s     = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      STREAM: begin
        rd_en_s  = 1'b1;
        k_next_s = k_r + K_ONE;
        if (k_r == K_LAST) begin
          state_next_s = ADVANCE;
        end else begin
          state_next_s = STREAM;
        end
      end
      ADVANCE: begin
        wptr_next_s  = wptr_r + K_ONE;
        k_next_s     = '0;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = CLEAR;
        k_next_s     = '0;
      end
    endcase
    ready_next_s = (state_next_s == IDLE);
  end

  // Newest sample sits at wptr; older taps walk backwards, wrapping naturally.
  assign hist_raddr_s = wptr_r - k_r;

  // FSM, counters and registered ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= CLEAR;
      k_r     <= '0;
      wptr_r  <= '0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      k_r     <= k_next_s;
      wptr_r  <= wptr_next_s;
      ready_r <= ready_next_s;
    end
  end

  // MAC framing flags, aligned with the one-cycle RAM read register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      valid_r <= (state_r == STREAM);
      first_r <= (state_r == STREAM) && (k_r == '0);
      last_r  <= (state_r == STREAM) && (k_r == K_LAST);
    end
  end

  fir_sample_ram #(.DW(SAMPLE_W), .DEPTH(NTAPS)) u_hist (
    .clk   (clk),
    .reset (reset),
    .we    (hist_we_s),
    .waddr (hist_waddr_s),
    .wdata (hist_wdata_s),
    .re    (rd_en_s),
    .raddr (hist_raddr_s),
    .rdata (mac_b)
  );

  fir_sample_ram #(.DW(COEF_W), .DEPTH(NTAPS)) u_coef (
    .clk   (clk),
    .reset (reset),
    .we    (coef_we_s),
    .waddr (coef_addr),
    .wdata (coef_wdata),
    .re    (rd_en_s),
    .raddr (k_r),
    .rdata (mac_a)
  );

  assign sample_ready = ready_r;
  assign mac_valid    = valid_r;
  assign mac_first    = first_r;
  assign mac_last     = last_r;
  // Same-cycle indication of a dropped sample; held low during reset.
  assign overrun      = sample_valid & ~ready_r & ~reset;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder
// Randomized self-checking bench. The reference model is a queue of accepted
// samples (newest last) plus a coefficient array; tap k of a sum expects the
// k-th newest accepted sample (zero if fewer were accepted since reset).
module tb_fir_sample_feeder;

  localparam int N  = 128;
  localparam int SW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;
  logic          coef_we;
  logic [6:0]    coef_addr;
  logic [CW-1:0] coef_wdata;
  logic [CW-1:0] mac_a;
  logic [SW-1:0] mac_b;
  logic          mac_valid;
  logic          mac_first;
  logic          mac_last;

  int n_chk  = 0;
  int n_pass = 0;

  logic [CW-1:0] coef_m [N];
  logic [SW-1:0] hist_q [$];

  fir_sample_feeder #(.NTAPS(N), .SAMPLE_W(SW), .COEF_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_valid    (mac_valid),
    .mac_first    (mac_first),
    .mac_last     (mac_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after reset drops: 128 cycles with ready low, then ready high.
  task automatic clear_phase();
    check("clear_ready0", sample_ready, 0);
    for (int c = 1; c < N; c++) begin
      tick();
      check("clear_ready0", sample_ready, 0);
    end
    tick();
    check("clear_ready1", sample_ready, 1);
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (sample_ready !== 1'b1 && c < 400) begin
      tick();
      c++;
    end
    check("ready_wait", sample_ready, 1);
  endtask

  task automatic write_coef(input logic [6:0] a, input logic [CW-1:0] d);
    wait_ready();
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    tick();
    coef_we = 1'b0;
    coef_m[a] = d;
  endtask

  // One accepted sample and its full stream. ovr_i / cw_i select the tap
  // cycle (0 = first MAC cycle) in which to inject a dropped sample or an
  // ignored coefficient write; -1 disables. cw_same writes a coefficient in
  // the handshake cycle itself.
  task automatic send(input logic [SW-1:0] v, input int ovr_i, input int cw_i,
                      input bit cw_same, input logic [6:0] ca, input logic [CW-1:0] cd);
    logic [SW-1:0] exp_b;
    int sz;
    wait_ready();
    sample_in = v; sample_valid = 1'b1;
    if (cw_same) begin
      coef_we = 1'b1; coef_addr = ca; coef_wdata = cd;
      coef_m[ca] = cd;
    end
    tick();
    sample_valid = 1'b0; coef_we = 1'b0; sample_in = SW'($urandom);
    hist_q.push_back(v);
    check("valid_t1", mac_valid, 0);
    check("ready_t1", sample_ready, 0);
    for (int i = 0; i < N; i++) begin
      tick();
      sample_valid = 1'b0; coef_we = 1'b0;
      if (i == ovr_i) begin
        sample_valid = 1'b1; sample_in = SW'($urandom);
      end
      if (i == cw_i) begin
        coef_we = 1'b1; coef_addr = 7'd0; coef_wdata = 16'h7FFF;
      end
      #1;
      sz = hist_q.size();
      exp_b = (i < sz) ? hist_q[sz - 1 - i] : 16'h0000;
      check("mac_valid", mac_valid, 1);
      check("mac_first", mac_first, (i == 0) ? 1 : 0);
      check("mac_last", mac_last, (i == N - 1) ? 1 : 0);
      check("mac_a", mac_a, coef_m[i]);
      check("mac_b", mac_b, exp_b);
      check("overrun", overrun, (i == ovr_i) ? 1 : 0);
      check("ready_busy", sample_ready, 0);
    end
    tick();
    sample_valid = 1'b0; coef_we = 1'b0;
    #1;
    check("valid_end", mac_valid, 0);
    check("a_end", mac_a, 0);
    check("b_end", mac_b, 0);
    check("first_end", mac_first, 0);
    check("last_end", mac_last, 0);
    check("ready_end", sample_ready, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, mac_valid, 0);
    check({tag, "_a"}, mac_a, 0);
    check({tag, "_b"}, mac_b, 0);
    check({tag, "_first"}, mac_first, 0);
    check({tag, "_last"}, mac_last, 0);
    check({tag, "_ready"}, sample_ready, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    reset = 1'b1; sample_in = '0; sample_valid = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    for (int k = 0; k < N; k++) coef_m[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    sample_valid = 1'b1;
    #1;
    check_outputs_zero("rst");
    sample_valid = 1'b0;
    reset = 1'b0;
    clear_phase();

    // Coefficients k+1, then the impulse pair.
    for (int k = 0; k < N; k++) write_coef(7'(k), 16'(k + 1));
    send(16'h0100, -1, -1, 1'b0, 7'd0, 16'h0000);
    send(16'h0002, -1, -1, 1'b0, 7'd0, 16'h0000);

    // Dropped sample mid-stream, then an unaffected stream.
    send(16'h1234, 3, -1, 1'b0, 7'd0, 16'h0000);
    send(16'h5678, -1, -1, 1'b0, 7'd0, 16'h0000);

    // Coefficient write during a stream is ignored.
    send(16'h0BAD, -1, 10, 1'b0, 7'd0, 16'h0000);
    send(16'h0C0D, -1, -1, 1'b0, 7'd0, 16'h0000);

    // Random samples with random coefficient updates, some in the handshake cycle.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(1, 0) == 1) write_coef(7'($urandom), CW'($urandom));
      send(SW'($urandom), ($urandom_range(3, 0) == 0) ? int'($urandom_range(N - 1, 0)) : -1,
           -1, 1'($urandom), 7'($urandom), CW'($urandom));
    end

    // Reset mid-stream at k=60: outputs drop at once, history is re-cleared.
    wait_ready();
    sample_in = 16'h4444; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (60) tick();
    reset = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (3) tick();
    reset = 1'b0;
    hist_q.delete();
    clear_phase();
    send(16'h0100, -1, -1, 1'b0, 7'd0, 16'h0000);

    // Wrap: 129 samples 1..129 after a fresh clear.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hist_q.delete();
    clear_phase();
    for (int n = 1; n <= N + 1; n++) send(16'(n), -1, -1, 1'b0, 7'd0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
